// File: rtl/mem_walk_seq.sv
// mem_walk_seq: walking-bit memory test sequencer.
// Writes pat(a) = p_SEED rotated left by (a mod p_DATA_WIDTH) to every address,
// reads every address back and compares against the same pattern. Each mismatch
// produces a one-cycle strobe with address/data/expected for the capture registers.
//
// Handshake: the memory has no back-pressure. o_WE and o_RE are single-cycle
// strobes qualified by o_ADDR (and o_WDATA for writes); i_RDATA must be valid
// exactly one cycle after the cycle in which o_RE is high. o_ERR_VALID is a
// one-cycle strobe and o_ERR_ADDR/DATA/EXP are valid in that same cycle.
module mem_walk_seq #(
  parameter int                      p_ADDR_WIDTH    = 4,
  parameter int                      p_DATA_WIDTH    = 8,
  parameter int                      p_DEPTH         = 16,
  parameter logic [p_DATA_WIDTH-1:0] p_SEED          = 1,
  parameter int                      p_ERR_CNT_WIDTH = 8
) (
  input  logic                       i_CLK,
  input  logic                       i_RST_N,
  input  logic                       i_START,
  input  logic [p_DATA_WIDTH-1:0]    i_RDATA,
  output logic [p_ADDR_WIDTH-1:0]    o_ADDR,
  output logic [p_DATA_WIDTH-1:0]    o_WDATA,
  output logic                       o_WE,
  output logic                       o_RE,
  output logic                       o_BUSY,
  output logic                       o_DONE,
  output logic                       o_PASS,
  output logic                       o_ERR_VALID,
  output logic [p_ADDR_WIDTH-1:0]    o_ERR_ADDR,
  output logic [p_DATA_WIDTH-1:0]    o_ERR_DATA,
  output logic [p_DATA_WIDTH-1:0]    o_ERR_EXP,
  output logic [p_ERR_CNT_WIDTH-1:0] o_ERR_CNT,
  output logic [2:0]                 o_STATE
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [p_ADDR_WIDTH-1:0]    ADDR_LAST = p_ADDR_WIDTH'(p_DEPTH - 1);
  localparam logic [p_ADDR_WIDTH-1:0]    ADDR_ONE  = p_ADDR_WIDTH'(1);
  localparam logic [p_ERR_CNT_WIDTH-1:0] CNT_ONE   = p_ERR_CNT_WIDTH'(1);

  state_t                       state;
  logic                         cmp_valid;
  logic [p_ADDR_WIDTH-1:0]      cmp_addr;
  logic [p_DATA_WIDTH-1:0]      cmp_exp;
  logic                         mismatch;
  logic [p_ERR_CNT_WIDTH-1:0]   cnt_next;

  // Rotate the seed left by (a mod data width); the doubled seed makes the wrap free.
  function automatic logic [p_DATA_WIDTH-1:0] pat(input logic [p_ADDR_WIDTH-1:0] a);
    logic [2*p_DATA_WIDTH-1:0] t;
    int sh;
    sh = int'(a) % p_DATA_WIDTH;
    t  = {p_SEED, p_SEED} << sh;
    return t[2*p_DATA_WIDTH-1:p_DATA_WIDTH];
  endfunction

  assign o_STATE = state;

  // Compare the returned word with the expected pattern and form the saturating count.
  always_comb begin
    mismatch = 1'b0;
    cnt_next = o_ERR_CNT;
    if (cmp_valid && (i_RDATA != cmp_exp)) begin
      mismatch = 1'b1;
      if (o_ERR_CNT != {p_ERR_CNT_WIDTH{1'b1}}) begin
        cnt_next = o_ERR_CNT + CNT_ONE;
      end
    end
  end

  // Sequencer FSM, compare pipeline and all registered outputs.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      state       <= S_IDLE;
      cmp_valid   <= 1'b0;
      cmp_addr    <= '0;
      cmp_exp     <= '0;
      o_ADDR      <= '0;
      o_WDATA     <= '0;
      o_WE        <= 1'b0;
      o_RE        <= 1'b0;
      o_BUSY      <= 1'b0;
      o_DONE      <= 1'b0;
      o_PASS      <= 1'b0;
      o_ERR_VALID <= 1'b0;
      o_ERR_ADDR  <= '0;
      o_ERR_DATA  <= '0;
      o_ERR_EXP   <= '0;
      o_ERR_CNT   <= '0;
    end else begin
      // The read issued this cycle is compared next cycle, when its data returns.
      cmp_valid   <= o_RE;
      cmp_addr    <= o_ADDR;
      cmp_exp     <= pat(o_ADDR);
      o_ERR_VALID <= mismatch;
      o_ERR_CNT   <= cnt_next;
      if (mismatch) begin
        o_ERR_ADDR <= cmp_addr;
        o_ERR_DATA <= i_RDATA;
        o_ERR_EXP  <= cmp_exp;
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (i_START) begin
            state     <= S_WRITE;
            o_WE      <= 1'b1;
            o_ADDR    <= '0;
            o_WDATA   <= pat('0);
            o_BUSY    <= 1'b1;
            o_DONE    <= 1'b0;
            o_PASS    <= 1'b0;
            o_ERR_CNT <= '0;
          end
        end
        S_WRITE: begin
          if (o_ADDR == ADDR_LAST) begin
            state   <= S_READ;
            o_WE    <= 1'b0;
            o_RE    <= 1'b1;
            o_ADDR  <= '0;
            o_WDATA <= '0;
          end else begin
            o_ADDR  <= o_ADDR + ADDR_ONE;
            o_WDATA <= pat(o_ADDR + ADDR_ONE);
          end
        end
        S_READ: begin
          if (o_ADDR == ADDR_LAST) begin
            state  <= S_DRAIN;
            o_RE   <= 1'b0;
            o_ADDR <= '0;
          end else begin
            o_ADDR <= o_ADDR + ADDR_ONE;
          end
        end
        S_DRAIN: begin
          // The last read is compared in this cycle, so PASS must see the updated count.
          state  <= S_DONE;
          o_BUSY <= 1'b0;
          o_DONE <= 1'b1;
          o_PASS <= (cnt_next == '0);
        end
        default: begin
          state <= S_IDLE;
          o_WE  <= 1'b0;
          o_RE  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_walk_seq.sv
// Directed bench for mem_walk_seq: three instances (default with ideal/faulty
// memory, stuck-at-0 memory with a 3-bit counter, depth 5 with seed 0x81).
module tb_mem_walk_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // instance 0: defaults, ideal memory with optional fault at address 3
  logic       start0, fault0;
  logic [7:0] rdata0 = 8'h00;
  logic [3:0] addr0, erra0;
  logic [7:0] wdata0, errd0, erre0, cnt0;
  logic       we0, re0, busy0, done0, pass0, errv0;
  logic [2:0] state0;
  logic [7:0] mem0 [16];

  // instance 1: stuck-at-0 memory, 3-bit counter
  logic       start1;
  logic [7:0] rdata1 = 8'h00;
  logic [3:0] addr1, erra1;
  logic [7:0] wdata1, errd1, erre1;
  logic [2:0] cnt1, state1;
  logic       we1, re1, busy1, done1, pass1, errv1;

  // instance 2: depth 5, seed 0x81, ideal memory
  logic       start2;
  logic [7:0] rdata2 = 8'h00;
  logic [3:0] addr2, erra2;
  logic [7:0] wdata2, errd2, erre2, cnt2;
  logic       we2, re2, busy2, done2, pass2, errv2;
  logic [2:0] state2;
  logic [7:0] mem2 [16];

  mem_walk_seq u0 (
    .i_CLK(clk), .i_RST_N(rst_n), .i_START(start0), .i_RDATA(rdata0),
    .o_ADDR(addr0), .o_WDATA(wdata0), .o_WE(we0), .o_RE(re0), .o_BUSY(busy0),
    .o_DONE(done0), .o_PASS(pass0), .o_ERR_VALID(errv0), .o_ERR_ADDR(erra0),
    .o_ERR_DATA(errd0), .o_ERR_EXP(erre0), .o_ERR_CNT(cnt0), .o_STATE(state0)
  );

  mem_walk_seq #(.p_ERR_CNT_WIDTH(3)) u1 (
    .i_CLK(clk), .i_RST_N(rst_n), .i_START(start1), .i_RDATA(rdata1),
    .o_ADDR(addr1), .o_WDATA(wdata1), .o_WE(we1), .o_RE(re1), .o_BUSY(busy1),
    .o_DONE(done1), .o_PASS(pass1), .o_ERR_VALID(errv1), .o_ERR_ADDR(erra1),
    .o_ERR_DATA(errd1), .o_ERR_EXP(erre1), .o_ERR_CNT(cnt1), .o_STATE(state1)
  );

  mem_walk_seq #(.p_DEPTH(5), .p_SEED(8'h81)) u2 (
    .i_CLK(clk), .i_RST_N(rst_n), .i_START(start2), .i_RDATA(rdata2),
    .o_ADDR(addr2), .o_WDATA(wdata2), .o_WE(we2), .o_RE(re2), .o_BUSY(busy2),
    .o_DONE(done2), .o_PASS(pass2), .o_ERR_VALID(errv2), .o_ERR_ADDR(erra2),
    .o_ERR_DATA(errd2), .o_ERR_EXP(erre2), .o_ERR_CNT(cnt2), .o_STATE(state2)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // memory models: one-cycle read latency
  always @(posedge clk) begin
    if (we0) mem0[addr0] <= wdata0;
    if (re0) rdata0 <= (fault0 && addr0 == 4'd3) ? 8'h09 : mem0[addr0];
    if (we2) mem2[addr2] <= wdata2;
    if (re2) rdata2 <= mem2[addr2];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_u0_zero(input string tag);
    check({tag, "_we"},    32'(we0),    0);
    check({tag, "_re"},    32'(re0),    0);
    check({tag, "_addr"},  32'(addr0),  0);
    check({tag, "_wdata"}, 32'(wdata0), 0);
    check({tag, "_busy"},  32'(busy0),  0);
    check({tag, "_done"},  32'(done0),  0);
    check({tag, "_pass"},  32'(pass0),  0);
    check({tag, "_errv"},  32'(errv0),  0);
    check({tag, "_erra"},  32'(erra0),  0);
    check({tag, "_errd"},  32'(errd0),  0);
    check({tag, "_erre"},  32'(erre0),  0);
    check({tag, "_cnt"},   32'(cnt0),   0);
    check({tag, "_state"}, 32'(state0), 0);
  endtask

  logic [7:0] pat_tab [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [7:0] tab2 [5]    = '{8'h81, 8'h03, 8'h06, 8'h0C, 8'h18};

  initial begin
    int pulses, pulse_cyc, first_cyc, last_cyc;
    logic [7:0] cap_addr, cap_data, cap_exp;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    fault0 = 1'b0;

    // reset
    step();
    step();
    check_u0_zero("reset");
    rst_n = 1'b1;
    step();

    // ideal memory, full pass
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("wr_we",    32'(we0),    1);
      check("wr_re",    32'(re0),    0);
      check("wr_addr",  32'(addr0),  i);
      check("wr_wdata", 32'(wdata0), 32'(pat_tab[i % 8]));
      check("wr_busy",  32'(busy0),  1);
      step();
    end
    for (int i = 0; i < 16; i++) begin
      check("rd_re",   32'(re0),   1);
      check("rd_we",   32'(we0),   0);
      check("rd_addr", 32'(addr0), i);
      check("rd_errv", 32'(errv0), 0);
      step();
    end
    check("drain_busy",   32'(busy0),       1);
    check("drain_done",   32'(done0),       0);
    check("drain_strobe", 32'({we0, re0}),  0);
    check("drain_errv",   32'(errv0),       0);
    step();
    check("done_done", 32'(done0), 1);
    check("done_pass", 32'(pass0), 1);
    check("done_cnt",  32'(cnt0),  0);
    check("done_errv", 32'(errv0), 0);
    check("done_busy", 32'(busy0), 0);
    step();
    check("done_hold", 32'(done0), 1);

    // restart from DONE with a fault at address 3; start pulsed mid-write
    fault0 = 1'b1;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    check("rs_we",    32'(we0),    1);
    check("rs_addr",  32'(addr0),  0);
    check("rs_wdata", 32'(wdata0), 8'h01);
    check("rs_cnt",   32'(cnt0),   0);
    check("rs_done",  32'(done0),  0);
    pulses = 0;
    pulse_cyc = 0;
    cap_addr = 0;
    cap_data = 0;
    cap_exp = 0;
    for (int cyc = 1; cyc <= 34; cyc++) begin
      if (cyc == 4) start0 = 1'b1;
      if (cyc == 5) start0 = 1'b0;
      if (errv0) begin
        pulses++;
        pulse_cyc = cyc;
        cap_addr = 8'(erra0);
        cap_data = errd0;
        cap_exp = erre0;
      end
      if (cyc == 16) check("mid_last_wr", 32'({we0, addr0}), 32'({1'b1, 4'd15}));
      if (cyc == 17) check("mid_first_rd", 32'({re0, addr0}), 32'({1'b1, 4'd0}));
      if (cyc < 34) step();
    end
    check("flt_pulses", pulses,          1);
    check("flt_cycle",  pulse_cyc,       22);
    check("flt_addr",   32'(cap_addr),   3);
    check("flt_data",   32'(cap_data),   8'h09);
    check("flt_exp",    32'(cap_exp),    8'h08);
    check("flt_done",   32'(done0),      1);
    check("flt_pass",   32'(pass0),      0);
    check("flt_cnt",    32'(cnt0),       1);
    step();
    check("flt_cnt_hold",  32'(cnt0),  1);
    check("flt_addr_hold", 32'(erra0), 3);
    check("flt_done_hold", 32'(done0), 1);

    // stuck-at-0 memory, 3-bit saturating counter
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    pulses = 0;
    first_cyc = 0;
    last_cyc = 0;
    for (int cyc = 1; cyc <= 34; cyc++) begin
      if (errv1) begin
        if (pulses == 0) first_cyc = cyc;
        pulses++;
        last_cyc = cyc;
      end
      if (cyc == 22) check("sa0_cnt_mid", 32'(cnt1), 4);
      if (cyc < 34) step();
    end
    check("sa0_pulses", pulses,       16);
    check("sa0_first",  first_cyc,    19);
    check("sa0_last",   last_cyc,     34);
    check("sa0_done",   32'(done1),   1);
    check("sa0_cnt",    32'(cnt1),    7);
    check("sa0_pass",   32'(pass1),   0);

    // depth 5, seed 0x81
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      check("d5_addr_max", 32'(addr2 <= 4'd4), 1);
      if (cyc <= 5) begin
        check("d5_we",    32'(we2),    1);
        check("d5_wdata", 32'(wdata2), 32'(tab2[cyc - 1]));
      end
      if (cyc == 6)  check("d5_first_rd", 32'({re2, addr2}), 32'({1'b1, 4'd0}));
      if (cyc == 11) check("d5_done_early", 32'(done2), 0);
      if (cyc == 12) begin
        check("d5_done", 32'(done2), 1);
        check("d5_pass", 32'(pass2), 1);
      end
      if (cyc < 12) step();
    end

    // reset during READ at a=5 aborts the test
    fault0 = 1'b0;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int i = 0; i < 21; i++) step();
    check("abort_rd5", 32'({re0, addr0}), 32'({1'b1, 4'd5}));
    rst_n = 1'b0;
    step();
    check_u0_zero("abort");
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      check("abort_quiet", 32'({we0, re0, errv0, done0}), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
